instr_mem_loader: RTL and testbench

//  Writer side of the CPU instruction store: takes a byte stream (UART RX or host bridge).

---
 rtl/instr_mem_loader_pkg.sv | 30 +++
 rtl/instr_mem_loader_word_assembler.sv | 48 ++++
 rtl/instr_mem_loader.sv | 182 ++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared instruction-format and loader-state definitions for the instruction store writer.
package instr_mem_loader_pkg;

    localparam int OPCODE_W       = 4;
    localparam int SEL_W          = 2;
    localparam int OPND_W         = 16;
    localparam int INSTR_W        = OPCODE_W + SEL_W + 2 * OPND_W;
    localparam int BYTES_PER_WORD = 5;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP, OP_MOV, OP_LDR, OP_STR, OP_CMP, OP_B,   OP_BGT, OP_BLT,
        OP_BEQ, OP_ADD, OP_SUB, OP_MUL, OP_LSR, OP_AND, OP_OR,  OP_MVN
    } opcode_e;

    typedef struct packed {
        opcode_e           opcode;
        logic [SEL_W-1:0]  s;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } instr_t;

    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, WORD, CHK, DONE, ERR
    } loader_state_e;

    function automatic logic is_busy(input loader_state_e st);
        return st inside {HDR_HI, HDR_LO, WORD, CHK};
    endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs 5 stream bytes MSB-first into one instruction word; flags completion and illegal top bits.
// Zero latency: word_dat/word_complete are valid combinationally with the 5th byte; no backpressure of its own.
module instr_mem_loader_word_assembler
    import instr_mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 38
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  byte_vld,
    input  logic [7:0]            byte_dat,
    output logic                  word_complete,
    output logic                  top_bits_bad,
    output logic [DATA_WIDTH-1:0] word_dat
);

    logic [31:0] shreg_q, shreg_d;
    logic [2:0]  cnt_q,   cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (byte_vld) begin
            shreg_d = {shreg_q[23:0], byte_dat};
            cnt_d   = (cnt_q == 3'(BYTES_PER_WORD - 1)) ? 3'd0 : cnt_q + 3'd1;
        end
    end

    // The four held bytes plus the byte on the bus form the full 40-bit word.
    assign word_complete = byte_vld && (cnt_q == 3'(BYTES_PER_WORD - 1));
    assign top_bits_bad  = byte_vld && (cnt_q == 3'd0) && (|byte_dat[7:6]);
    assign word_dat      = DATA_WIDTH'({shreg_q, byte_dat});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a checksummed byte-stream frame into instruction RAM and holds the CPU until it succeeds.
// wr_en one cycle after a word's 5th byte; rx_ready is purely state-based and drops outside the frame.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 38,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned MAX_N = 1 << ADDR_WIDTH;

    loader_state_e         state_q, state_d;
    logic [7:0]            n_hi_q, n_hi_d;
    logic [15:0]           n_q, n_d;
    logic [7:0]            chk_q, chk_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  hold_q, hold_d;

    logic                  accept;
    logic                  asm_clear;
    logic                  asm_vld;
    logic                  asm_complete;
    logic                  asm_bad;
    logic [DATA_WIDTH-1:0] asm_word;
    logic [15:0]           n_new;

    assign rx_ready = is_busy(state_q);
    assign accept   = rx_valid && rx_ready;
    assign asm_vld  = accept && (state_q == WORD);
    assign n_new    = {n_hi_q, rx_data};

    instr_mem_loader_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_asm (
        .clk           (clk),
        .rst           (rst),
        .clear         (asm_clear),
        .byte_vld      (asm_vld),
        .byte_dat      (rx_data),
        .word_complete (asm_complete),
        .top_bits_bad  (asm_bad),
        .word_dat      (asm_word)
    );

    always_comb begin
        state_d   = state_q;
        n_hi_d    = n_hi_q;
        n_d       = n_q;
        chk_d     = chk_q;
        words_d   = words_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        error_d   = error_q;
        asm_clear = 1'b0;

        if (accept && state_q != CHK) begin
            chk_d = chk_q ^ rx_data;
        end

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d   = HDR_HI;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    words_d   = '0;
                    chk_d     = '0;
                    asm_clear = 1'b1;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    n_hi_d  = rx_data;
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    n_d = n_new;
                    if (n_new == 16'd0 || 32'(n_new) > MAX_N) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = WORD;
                    end
                end
            end
            WORD: begin
                if (asm_bad) begin
                    state_d = ERR;
                    error_d = 1'b1;
                end else if (asm_complete) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = words_q[ADDR_WIDTH-1:0];
                    wr_data_d = asm_word;
                    words_d   = words_q + (ADDR_WIDTH+1)'(1);
                    if (32'(words_d) == 32'(n_q)) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    if (rx_data == chk_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = is_busy(state_d);
        hold_d = busy_d | error_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            n_hi_q    <= '0;
            n_q       <= '0;
            chk_q     <= '0;
            words_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_hi_q    <= n_hi_d;
            n_q       <= n_d;
            chk_q     <= chk_d;
            words_q   <= words_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            hold_q    <= hold_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_hold     = hold_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: frame table plus hand sequences, with a write scoreboard.
module tb_instr_mem_loader;

    localparam int DW = 38;
    localparam int AW = 12;

    logic          clk;
    logic          rst;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_hold;
    logic [AW:0]   words_loaded;

    instr_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .cpu_hold     (cpu_hold),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] b[13];
        int         len;
        int         gap;
        int         start_at;
        bit         exp_done;
        bit         exp_err;
        int         exp_words;
    } vec_t;

    wr_t        exp_q[$];
    logic [7:0] tx_q[$];
    int         last_addr = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every RAM write must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr: got addr %0h data %0h expected no write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", 64'(wr_data), 64'(e.data));
                    last_addr = int'(wr_addr);
                end
            end
        end
    end

    // Reference: every complete, legal word of a frame with a legal count is written in order.
    task automatic model_frame();
        int          n;
        int          base;
        logic [39:0] wd;
        wr_t         e;
        if (tx_q.size() < 2) return;
        n = {tx_q[0], tx_q[1]};
        if (n == 0 || n > (1 << AW)) return;
        for (int w = 0; w < n; w++) begin
            base = 2 + 5 * w;
            if (base + 5 > tx_q.size()) break;
            if (tx_q[base][7:6] != 2'b00) break;
            wd = {tx_q[base], tx_q[base+1], tx_q[base+2], tx_q[base+3], tx_q[base+4]};
            e.addr = AW'(w);
            e.data = wd[DW-1:0];
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_done_clr", 64'(done), 64'd0);
        check("start_err_clr", 64'(error), 64'd0);
        check("start_words_clr", 64'(words_loaded), 64'd0);
        check("start_hold", 64'(cpu_hold), 64'd1);
    endtask

    task automatic send_frame(input int gap_max, input int start_at);
        int t;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (i == start_at) begin
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    @(posedge clk);
                    #1;
                end
            end
            rx_data  = tx_q[i];
            rx_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!rx_ready) begin
                t++;
                if (t > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_ready_timeout: byte %0d got ready=0 expected 1", i);
                    @(posedge clk);
                    #1 rx_valid = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            @(posedge clk);
            #1 rx_valid = 1'b0;
        end
    endtask

    task automatic check_final(input string tag, input bit d, input bit e, input int wl);
        check({tag, "_done"}, 64'(done), 64'(d));
        check({tag, "_error"}, 64'(error), 64'(e));
        check({tag, "_hold"}, 64'(cpu_hold), 64'(e));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'(wl));
        repeat (3) @(posedge clk);
        #1 check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    vec_t vecs[6];

    initial begin
        logic [7:0] cs;
        vecs[0] = '{b: '{8'h00, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h04, 8'h10, 8'h00, 8'h00, 8'h02, 8'h11},
                    len: 13, gap: 0, start_at: -1, exp_done: 1'b1, exp_err: 1'b0, exp_words: 2};
        vecs[1] = '{b: '{8'h00, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h04, 8'h10, 8'h00, 8'h00, 8'h02, 8'h12},
                    len: 13, gap: 0, start_at: -1, exp_done: 1'b0, exp_err: 1'b1, exp_words: 2};
        vecs[2] = '{b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    len: 2, gap: 0, start_at: -1, exp_done: 1'b0, exp_err: 1'b1, exp_words: 0};
        vecs[3] = '{b: '{8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    len: 2, gap: 0, start_at: -1, exp_done: 1'b0, exp_err: 1'b1, exp_words: 0};
        vecs[4] = '{b: '{8'h00, 8'h01, 8'hC4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    len: 3, gap: 0, start_at: -1, exp_done: 1'b0, exp_err: 1'b1, exp_words: 0};
        vecs[5] = '{b: '{8'h00, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h04, 8'h10, 8'h00, 8'h00, 8'h02, 8'h11},
                    len: 13, gap: 7, start_at: 6, exp_done: 1'b1, exp_err: 1'b0, exp_words: 2};

        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(posedge clk);
        #1;
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_hold", 64'(cpu_hold), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            tx_q.delete();
            for (int j = 0; j < vecs[v].len; j++) tx_q.push_back(vecs[v].b[j]);
            model_frame();
            pulse_start();
            send_frame(vecs[v].gap, vecs[v].start_at);
            check_final($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_words);
        end

        // Reset in the middle of the second word: only word 0 reaches RAM.
        tx_q.delete();
        for (int j = 0; j < 10; j++) tx_q.push_back(vecs[0].b[j]);
        model_frame();
        pulse_start();
        send_frame(0, -1);
        rst = 1'b1;
        #2;
        check("midrst_rx_ready", 64'(rx_ready), 64'd0);
        check("midrst_wr_en", 64'(wr_en), 64'd0);
        check("midrst_wr_addr", 64'(wr_addr), 64'd0);
        check("midrst_wr_data", 64'(wr_data), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_error", 64'(error), 64'd0);
        check("midrst_hold", 64'(cpu_hold), 64'd0);
        check("midrst_words", 64'(words_loaded), 64'd0);
        check("midrst_sb_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        tx_q.delete();
        for (int j = 0; j < 13; j++) tx_q.push_back(vecs[0].b[j]);
        model_frame();
        pulse_start();
        send_frame(0, -1);
        check_final("after_rst", 1'b1, 1'b0, 2);

        // Full-capacity frame: last write lands on the top address with no wrap.
        tx_q.delete();
        tx_q.push_back(8'h10);
        tx_q.push_back(8'h00);
        for (int w = 0; w < (1 << AW); w++) begin
            tx_q.push_back(8'((w >> 6) & 63));
            tx_q.push_back(8'(w));
            tx_q.push_back(8'(w * 3));
            tx_q.push_back(8'hA5);
            tx_q.push_back(8'(~w));
        end
        cs = 8'h00;
        foreach (tx_q[k]) cs = cs ^ tx_q[k];
        tx_q.push_back(cs);
        model_frame();
        pulse_start();
        send_frame(0, -1);
        check("full_last_addr", 64'(last_addr), 64'((1 << AW) - 1));
        check_final("full", 1'b1, 1'b0, 1 << AW);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
